// File: rtl/operand_bypass_net_pkg.sv
// Shared types and encodings for the operand bypass network.
package operand_bypass_net_pkg;

   // Storage width of the ready-stage field in a tag entry; the stage-index
   // parameter SW of the top level must not exceed this.
   localparam int TAG_SW = 4;

   // op_src encodings: GPR, WB, and stage k reported as SRC_STG_BASE + k.
   localparam int SRC_GPR      = 0;
   localparam int SRC_WB       = 1;
   localparam int SRC_STG_BASE = 2;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // One in-flight producer: valid, destination register, stage where its result first exists.
   typedef struct packed {
      logic              v;
      logic [4:0]        waddr;
      logic [TAG_SW-1:0] rdy_stg;
   } tag_t;

endpackage

// File: rtl/operand_bypass_net_port_sel.sv
// Single read port priority search: youngest stage first, then WB, then GPR.
module bypass_port_sel
   import operand_bypass_net_pkg::*;
#(
   parameter int DW     = 32,
   parameter int NSTAGE = 3,
   parameter int SW     = 2
) (
   input  logic                 [NSTAGE-1:0] tags_valid_unused_i,
   input  tag_t    [NSTAGE-1:0]              tags_i,
   input  logic    [NSTAGE*DW-1:0]           stg_data_i,
   input  logic                              wb_wen_i,
   input  logic    [4:0]                     wb_waddr_i,
   input  logic    [DW-1:0]                  wb_wdata_i,
   input  logic    [4:0]                     rd_addr_i,
   input  logic    [DW-1:0]                  gpr_data_i,
   output logic    [DW-1:0]                  op_data_o,
   output logic    [SW:0]                    op_src_o,
   output logic                              not_ready_o
);

   // Walk from oldest to youngest so the youngest match overrides all older ones.
   always_comb begin
      op_data_o   = gpr_data_i;
      op_src_o    = (SW+1)'(SRC_GPR);
      not_ready_o = 1'b0;
      if (rd_addr_i != REG_ZERO) begin
         if (wb_wen_i && (wb_waddr_i == rd_addr_i)) begin
            op_data_o = wb_wdata_i;
            op_src_o  = (SW+1)'(SRC_WB);
         end
         for (int k = NSTAGE-1; k >= 0; k--) begin
            if (tags_i[k].v && (tags_i[k].waddr == rd_addr_i)) begin
               op_src_o = (SW+1)'(SRC_STG_BASE + k);
               if (k >= int'(tags_i[k].rdy_stg)) begin
                  op_data_o   = stg_data_i[k*DW +: DW];
                  not_ready_o = 1'b0;
               end else begin
                  op_data_o   = gpr_data_i;
                  not_ready_o = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/operand_bypass_net.sv
// Operand bypass network: tag pipeline of in-flight producers, per-port
// forwarding selects, load-use stall and a saturating stall counter.
module operand_bypass_net
   import operand_bypass_net_pkg::*;
#(
   parameter int DW     = 32,
   parameter int NUM_RD = 2,
   parameter int NSTAGE = 3,
   parameter int SW     = 2,
   parameter int CW     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     adv,
   input  logic                     flush,
   input  logic                     id_valid,
   input  logic                     id_wen,
   input  logic [4:0]               id_waddr,
   input  logic [SW-1:0]            id_rdy_stg,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*5-1:0]      rd_addr,
   input  logic [NUM_RD*DW-1:0]     gpr_data,
   input  logic [NSTAGE*DW-1:0]     stg_data,
   input  logic                     wb_wen,
   input  logic [4:0]               wb_waddr,
   input  logic [DW-1:0]            wb_wdata,
   output logic [NUM_RD*DW-1:0]     op_data,
   output logic [NUM_RD*(SW+1)-1:0] op_src,
   output logic                     stall,
   output logic [CW-1:0]            stall_cnt
);

   tag_t [NSTAGE-1:0] tags_q, tags_d;
   logic [NUM_RD-1:0] not_ready;
   logic [CW-1:0]     stall_cnt_q, stall_cnt_d;
   logic [NSTAGE-1:0] tag_v;

   generate
      for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_tag_v
         assign tag_v[gi] = tags_q[gi].v;
      end
      for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
         bypass_port_sel #(
            .DW     (DW),
            .NSTAGE (NSTAGE),
            .SW     (SW)
         ) u_sel (
            .tags_valid_unused_i (tag_v),
            .tags_i              (tags_q),
            .stg_data_i          (stg_data),
            .wb_wen_i            (wb_wen),
            .wb_waddr_i          (wb_waddr),
            .wb_wdata_i          (wb_wdata),
            .rd_addr_i           (rd_addr[gi*5 +: 5]),
            .gpr_data_i          (gpr_data[gi*DW +: DW]),
            .op_data_o           (op_data[gi*DW +: DW]),
            .op_src_o            (op_src[gi*(SW+1) +: SW+1]),
            .not_ready_o         (not_ready[gi])
         );
      end
   endgenerate

   // A used operand whose youngest producer is not ready yet holds ID.
   assign stall = id_valid & ~flush & (|(rd_en & not_ready));

   // Tag pipeline next state: flush kills, advance shifts and inserts ID (bubble on stall).
   always_comb begin
      tags_d = tags_q;
      if (flush) begin
         for (int k = 0; k < NSTAGE; k++) begin
            tags_d[k].v = 1'b0;
         end
      end else if (adv) begin
         for (int k = NSTAGE-1; k > 0; k--) begin
            tags_d[k] = tags_q[k-1];
         end
         tags_d[0].v       = id_valid & id_wen & ~stall & (id_waddr != REG_ZERO);
         tags_d[0].waddr   = id_waddr;
         tags_d[0].rdy_stg = TAG_SW'(id_rdy_stg);
      end
   end

   // Tag pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tags_q <= '0;
      end else begin
         tags_q <= tags_d;
      end
   end

   // Stall statistics: count stalled advancing cycles, saturating at all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && adv && (stall_cnt_q != {CW{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // Stall counter register; flush deliberately leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_bypass_net.sv
// Scoreboard bench for operand_bypass_net (small counter width to reach saturation).
module tb_operand_bypass_net;

   localparam int DW     = 32;
   localparam int NUM_RD = 2;
   localparam int NSTAGE = 3;
   localparam int SW     = 2;
   localparam int CW     = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   localparam logic [DW-1:0] GPR0 = 32'h6060_0000;
   localparam logic [DW-1:0] GPR1 = 32'h6161_0001;
   localparam logic [DW-1:0] STG0 = 32'h0000_1234;
   localparam logic [DW-1:0] STG1 = 32'h0000_5678;
   localparam logic [DW-1:0] STG2 = 32'h0000_9ABC;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     adv, flush, id_valid, id_wen;
   logic [4:0]               id_waddr;
   logic [SW-1:0]            id_rdy_stg;
   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*5-1:0]      rd_addr;
   logic [NUM_RD*DW-1:0]     gpr_data;
   logic [NSTAGE*DW-1:0]     stg_data;
   logic                     wb_wen;
   logic [4:0]               wb_waddr;
   logic [DW-1:0]            wb_wdata;
   logic [NUM_RD*DW-1:0]     op_data;
   logic [NUM_RD*(SW+1)-1:0] op_src;
   logic                     stall;
   logic [CW-1:0]            stall_cnt;

   typedef struct {
      string         name;
      int            port;
      logic          chk_d;
      logic [DW-1:0] data;
      logic [SW:0]   src;
      logic          stl;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          sb[$];
   exp_t          e;
   int            n_cmp = 0;
   int            n_err = 0;
   int            exp_cnt = 0;
   logic [DW-1:0] got_d;
   logic [SW:0]   got_s;

   operand_bypass_net #(
      .DW(DW), .NUM_RD(NUM_RD), .NSTAGE(NSTAGE), .SW(SW), .CW(CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .adv        (adv),
      .flush      (flush),
      .id_valid   (id_valid),
      .id_wen     (id_wen),
      .id_waddr   (id_waddr),
      .id_rdy_stg (id_rdy_stg),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .gpr_data   (gpr_data),
      .stg_data   (stg_data),
      .wb_wen     (wb_wen),
      .wb_waddr   (wb_waddr),
      .wb_wdata   (wb_wdata),
      .op_data    (op_data),
      .op_src     (op_src),
      .stall      (stall),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      adv = 1'b1; flush = 1'b0; id_valid = 1'b0; id_wen = 1'b0;
      id_waddr = 5'd0; id_rdy_stg = '0; rd_en = '0; rd_addr = '0;
      wb_wen = 1'b0; wb_waddr = 5'd0; wb_wdata = '0;
   endtask

   // Issue a GPR-writing producer in ID with no operand use, then advance into EX.
   task automatic issue(input logic [4:0] waddr, input logic [SW-1:0] rdy);
      id_valid = 1'b1; id_wen = 1'b1; id_waddr = waddr; id_rdy_stg = rdy; rd_en = '0;
      step();
      id_valid = 1'b0; id_wen = 1'b0;
   endtask

   task automatic drain_pipe();
      idle_inputs();
      repeat (NSTAGE) step();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      id_valid = 1'b1; rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
      step();
      sb.push_back('{"reset", 0, 1'b1, GPR0, 3'd0, 1'b0, CW'(0)});
      #2;
      while (sb.size() != 0) begin
         e = sb.pop_front(); n_cmp++;
         got_d = op_data[e.port*DW +: DW]; got_s = op_src[e.port*(SW+1) +: SW+1];
         if (got_s !== e.src || (e.chk_d && got_d !== e.data) || stall !== e.stl || stall_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL %s p%0d: got src=%0d data=%h stall=%b cnt=%0d, want src=%0d data=%h stall=%b cnt=%0d",
                     e.name, e.port, got_s, got_d, stall, stall_cnt, e.src, e.data, e.stl, e.cnt);
         end else $display("txn %s p%0d src=%0d data=%h stall=%b cnt=%0d", e.name, e.port, got_s, got_d, stall, stall_cnt);
      end
      @(negedge clk) rst_n = 1'b1;
      idle_inputs();
      step();
   endtask

   task automatic test_alu_b2b();
      issue(5'd5, 2'd0);
      id_valid = 1'b1; rd_en = 2'b11; rd_addr = {5'd9, 5'd5};
      sb.push_back('{"alu_b2b", 0, 1'b1, STG0, 3'd2, 1'b0, CW'(exp_cnt)});
      sb.push_back('{"alu_b2b_other", 1, 1'b1, GPR1, 3'd0, 1'b0, CW'(exp_cnt)});
      #2;
      while (sb.size() != 0) begin
         e = sb.pop_front(); n_cmp++;
         got_d = op_data[e.port*DW +: DW]; got_s = op_src[e.port*(SW+1) +: SW+1];
         if (got_s !== e.src || (e.chk_d && got_d !== e.data) || stall !== e.stl || stall_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL %s p%0d: got src=%0d data=%h stall=%b cnt=%0d, want src=%0d data=%h stall=%b cnt=%0d",
                     e.name, e.port, got_s, got_d, stall, stall_cnt, e.src, e.data, e.stl, e.cnt);
         end else $display("txn %s p%0d src=%0d data=%h stall=%b cnt=%0d", e.name, e.port, got_s, got_d, stall, stall_cnt);
      end
      drain_pipe();
   endtask

   task automatic test_load_use();
      logic [SW:0]   srcs [3];
      logic          stls [3];
      srcs = '{3'd2, 3'd3, 3'd4};
      stls = '{1'b1, 1'b1, 1'b0};
      issue(5'd8, 2'd2);
      id_valid = 1'b1; id_wen = 1'b1; id_waddr = 5'd9; id_rdy_stg = 2'd0;
      rd_en = 2'b01; rd_addr = {5'd0, 5'd8};
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{"load_use", 0, !stls[i], STG2, srcs[i], stls[i], CW'(exp_cnt)});
         #2;
         while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            got_d = op_data[e.port*DW +: DW]; got_s = op_src[e.port*(SW+1) +: SW+1];
            if (got_s !== e.src || (e.chk_d && got_d !== e.data) || stall !== e.stl || stall_cnt !== e.cnt) begin
               n_err++;
               $display("FAIL %s p%0d: got src=%0d data=%h stall=%b cnt=%0d, want src=%0d data=%h stall=%b cnt=%0d",
                        e.name, e.port, got_s, got_d, stall, stall_cnt, e.src, e.data, e.stl, e.cnt);
            end else $display("txn %s p%0d src=%0d data=%h stall=%b cnt=%0d", e.name, e.port, got_s, got_d, stall, stall_cnt);
         end
         step();
         if (stls[i]) exp_cnt++;
      end
      drain_pipe();
   endtask

   task automatic test_youngest();
      issue(5'd3, 2'd0);
      step();
      issue(5'd3, 2'd1);
      id_valid = 1'b1; rd_en = 2'b10; rd_addr = {5'd3, 5'd0};
      sb.push_back('{"youngest", 1, 1'b1, GPR1, 3'd2, 1'b1, CW'(exp_cnt)});
      #2;
      while (sb.size() != 0) begin
         e = sb.pop_front(); n_cmp++;
         got_d = op_data[e.port*DW +: DW]; got_s = op_src[e.port*(SW+1) +: SW+1];
         if (got_s !== e.src || (e.chk_d && got_d !== e.data) || stall !== e.stl || stall_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL %s p%0d: got src=%0d data=%h stall=%b cnt=%0d, want src=%0d data=%h stall=%b cnt=%0d",
                     e.name, e.port, got_s, got_d, stall, stall_cnt, e.src, e.data, e.stl, e.cnt);
         end else $display("txn %s p%0d src=%0d data=%h stall=%b cnt=%0d", e.name, e.port, got_s, got_d, stall, stall_cnt);
      end
      drain_pipe();
   endtask

   task automatic test_wb_r0();
      wb_wen = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h0000_CAFE;
      id_valid = 1'b1; id_wen = 1'b1; id_waddr = 5'd0; id_rdy_stg = 2'd0;
      rd_en = 2'b11; rd_addr = {5'd0, 5'd7};
      sb.push_back('{"wb_fwd", 0, 1'b1, 32'h0000_CAFE, 3'd1, 1'b0, CW'(exp_cnt)});
      sb.push_back('{"r0_read", 1, 1'b1, GPR1, 3'd0, 1'b0, CW'(exp_cnt)});
      #2;
      while (sb.size() != 0) begin
         e = sb.pop_front(); n_cmp++;
         got_d = op_data[e.port*DW +: DW]; got_s = op_src[e.port*(SW+1) +: SW+1];
         if (got_s !== e.src || (e.chk_d && got_d !== e.data) || stall !== e.stl || stall_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL %s p%0d: got src=%0d data=%h stall=%b cnt=%0d, want src=%0d data=%h stall=%b cnt=%0d",
                     e.name, e.port, got_s, got_d, stall, stall_cnt, e.src, e.data, e.stl, e.cnt);
         end else $display("txn %s p%0d src=%0d data=%h stall=%b cnt=%0d", e.name, e.port, got_s, got_d, stall, stall_cnt);
      end
      step();
      // The r0 write above must not have created a tag; WB to r0 is ignored too.
      id_wen = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'h0000_DEAD;
      rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
      sb.push_back('{"r0_no_tag", 0, 1'b1, GPR0, 3'd0, 1'b0, CW'(exp_cnt)});
      #2;
      while (sb.size() != 0) begin
         e = sb.pop_front(); n_cmp++;
         got_d = op_data[e.port*DW +: DW]; got_s = op_src[e.port*(SW+1) +: SW+1];
         if (got_s !== e.src || (e.chk_d && got_d !== e.data) || stall !== e.stl || stall_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL %s p%0d: got src=%0d data=%h stall=%b cnt=%0d, want src=%0d data=%h stall=%b cnt=%0d",
                     e.name, e.port, got_s, got_d, stall, stall_cnt, e.src, e.data, e.stl, e.cnt);
         end else $display("txn %s p%0d src=%0d data=%h stall=%b cnt=%0d", e.name, e.port, got_s, got_d, stall, stall_cnt);
      end
      drain_pipe();
   endtask

   task automatic test_hold();
      issue(5'd10, 2'd2);
      adv = 1'b0; id_valid = 1'b1; rd_en = 2'b01; rd_addr = {5'd0, 5'd10};
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            adv = 1'b1;
            step();
            exp_cnt++;
         end
         sb.push_back('{"adv_hold", 0, 1'b0, GPR0, (i == 4) ? 3'd3 : 3'd2, 1'b1, CW'(exp_cnt)});
         #2;
         while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            got_d = op_data[e.port*DW +: DW]; got_s = op_src[e.port*(SW+1) +: SW+1];
            if (got_s !== e.src || (e.chk_d && got_d !== e.data) || stall !== e.stl || stall_cnt !== e.cnt) begin
               n_err++;
               $display("FAIL %s p%0d: got src=%0d data=%h stall=%b cnt=%0d, want src=%0d data=%h stall=%b cnt=%0d",
                        e.name, e.port, got_s, got_d, stall, stall_cnt, e.src, e.data, e.stl, e.cnt);
            end else $display("txn %s p%0d src=%0d data=%h stall=%b cnt=%0d", e.name, e.port, got_s, got_d, stall, stall_cnt);
         end
         if (i < 3) step();
      end
      drain_pipe();
   endtask

   task automatic test_flush_reset();
      issue(5'd12, 2'd2);
      id_valid = 1'b1; rd_en = 2'b01; rd_addr = {5'd0, 5'd12};
      flush = 1'b1;
      // flush masks the stall at once; the tag itself clears on the edge.
      sb.push_back('{"flush_now", 0, 1'b0, GPR0, 3'd2, 1'b0, CW'(exp_cnt)});
      #2;
      while (sb.size() != 0) begin
         e = sb.pop_front(); n_cmp++;
         got_d = op_data[e.port*DW +: DW]; got_s = op_src[e.port*(SW+1) +: SW+1];
         if (got_s !== e.src || (e.chk_d && got_d !== e.data) || stall !== e.stl || stall_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL %s p%0d: got src=%0d data=%h stall=%b cnt=%0d, want src=%0d data=%h stall=%b cnt=%0d",
                     e.name, e.port, got_s, got_d, stall, stall_cnt, e.src, e.data, e.stl, e.cnt);
         end else $display("txn %s p%0d src=%0d data=%h stall=%b cnt=%0d", e.name, e.port, got_s, got_d, stall, stall_cnt);
      end
      step();
      flush = 1'b0;
      sb.push_back('{"flush_after", 0, 1'b1, GPR0, 3'd0, 1'b0, CW'(exp_cnt)});
      #2;
      while (sb.size() != 0) begin
         e = sb.pop_front(); n_cmp++;
         got_d = op_data[e.port*DW +: DW]; got_s = op_src[e.port*(SW+1) +: SW+1];
         if (got_s !== e.src || (e.chk_d && got_d !== e.data) || stall !== e.stl || stall_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL %s p%0d: got src=%0d data=%h stall=%b cnt=%0d, want src=%0d data=%h stall=%b cnt=%0d",
                     e.name, e.port, got_s, got_d, stall, stall_cnt, e.src, e.data, e.stl, e.cnt);
         end else $display("txn %s p%0d src=%0d data=%h stall=%b cnt=%0d", e.name, e.port, got_s, got_d, stall, stall_cnt);
      end
      drain_pipe();
      issue(5'd13, 2'd2);
      id_valid = 1'b1; rd_en = 2'b01; rd_addr = {5'd0, 5'd13};
      step();
      exp_cnt++;
      sb.push_back('{"pre_reset", 0, 1'b0, GPR0, 3'd3, 1'b1, CW'(exp_cnt)});
      #2;
      while (sb.size() != 0) begin
         e = sb.pop_front(); n_cmp++;
         got_d = op_data[e.port*DW +: DW]; got_s = op_src[e.port*(SW+1) +: SW+1];
         if (got_s !== e.src || (e.chk_d && got_d !== e.data) || stall !== e.stl || stall_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL %s p%0d: got src=%0d data=%h stall=%b cnt=%0d, want src=%0d data=%h stall=%b cnt=%0d",
                     e.name, e.port, got_s, got_d, stall, stall_cnt, e.src, e.data, e.stl, e.cnt);
         end else $display("txn %s p%0d src=%0d data=%h stall=%b cnt=%0d", e.name, e.port, got_s, got_d, stall, stall_cnt);
      end
      // Asynchronous reset mid-cycle, away from any clock edge.
      rst_n = 1'b0;
      exp_cnt = 0;
      sb.push_back('{"async_reset", 0, 1'b1, GPR0, 3'd0, 1'b0, CW'(exp_cnt)});
      #1;
      while (sb.size() != 0) begin
         e = sb.pop_front(); n_cmp++;
         got_d = op_data[e.port*DW +: DW]; got_s = op_src[e.port*(SW+1) +: SW+1];
         if (got_s !== e.src || (e.chk_d && got_d !== e.data) || stall !== e.stl || stall_cnt !== e.cnt) begin
            n_err++;
            $display("FAIL %s p%0d: got src=%0d data=%h stall=%b cnt=%0d, want src=%0d data=%h stall=%b cnt=%0d",
                     e.name, e.port, got_s, got_d, stall, stall_cnt, e.src, e.data, e.stl, e.cnt);
         end else $display("txn %s p%0d src=%0d data=%h stall=%b cnt=%0d", e.name, e.port, got_s, got_d, stall, stall_cnt);
      end
      idle_inputs();
      @(negedge clk) rst_n = 1'b1;
      step();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 9; i++) begin
         issue(5'd14, 2'd2);
         id_valid = 1'b1; rd_en = 2'b01; rd_addr = {5'd0, 5'd14};
         step();
         step();
         exp_cnt = (exp_cnt + 2 > CNT_MAX) ? CNT_MAX : exp_cnt + 2;
         sb.push_back('{"cnt_sat", 0, 1'b1, STG2, 3'd4, 1'b0, CW'(exp_cnt)});
         #2;
         while (sb.size() != 0) begin
            e = sb.pop_front(); n_cmp++;
            got_d = op_data[e.port*DW +: DW]; got_s = op_src[e.port*(SW+1) +: SW+1];
            if (got_s !== e.src || (e.chk_d && got_d !== e.data) || stall !== e.stl || stall_cnt !== e.cnt) begin
               n_err++;
               $display("FAIL %s p%0d: got src=%0d data=%h stall=%b cnt=%0d, want src=%0d data=%h stall=%b cnt=%0d",
                        e.name, e.port, got_s, got_d, stall, stall_cnt, e.src, e.data, e.stl, e.cnt);
            end else $display("txn %s p%0d src=%0d data=%h stall=%b cnt=%0d", e.name, e.port, got_s, got_d, stall, stall_cnt);
         end
         idle_inputs();
      end
   endtask

   initial begin
      gpr_data = {GPR1, GPR0};
      stg_data = {STG2, STG1, STG0};
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_alu_b2b();
      test_load_use();
      test_youngest();
      test_wb_r0();
      test_hold();
      test_flush_reset();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/operand_bypass_net.md
Name: operand_bypass_net

Overview:
- Parametrised successor to the fixed 4-way rs/rt forwarding selects.
- Tracks destination tags of in-flight instructions in an internal tag pipeline of NSTAGE stages (stage 0 = EX).
- For each of NUM_RD decode-stage read ports it forwards the youngest ready producer, falls back to the WB write or the GPR value, and raises a load-use stall when the producer's result is not yet available.
- Sits between the register file / ID stage and the EX input registers.

Parameters:
- DW, 32, data width
- NUM_RD, 2, number of operand read ports (rs, rt, ...)
- NSTAGE, 3, tracked producer stages after ID (EX, MEM1, MEM2)
- SW, 2, width of stage index; must satisfy 2^SW >= NSTAGE
- CW, 16, width of the stall statistics counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- adv  in  1  pipeline advances this cycle; 0 = downstream hold, all tags frozen
- flush  in  1  kill all in-flight tags (exception/eret)
- id_valid  in  1  ID holds a valid instruction
- id_wen  in  1  ID instruction writes a GPR
- id_waddr  in  5  ID destination register
- id_rdy_stg  in  SW  stage index at which the result first exists (0 = ALU in EX, 2 = load in MEM2)
- rd_en  in  NUM_RD  read port p uses its operand
- rd_addr  in  NUM_RD*5  source register per port, port p at bits [5p+4:5p]
- gpr_data  in  NUM_RD*DW  register-file read data per port
- stg_data  in  NSTAGE*DW  result currently held in stage k
- wb_wen  in  1  WB writes the register file this cycle
- wb_waddr  in  5  WB destination
- wb_wdata  in  DW  WB data
- op_data  out  NUM_RD*DW  resolved operand per port
- op_src  out  NUM_RD*(SW+1)  per port: 0 = GPR, 1 = WB, k+2 = stage k
- stall  out  1  hold ID/IF, insert bubble into EX
- stall_cnt  out  CW  saturating count of stall cycles

Behaviour:
Tag pipeline
- NSTAGE entries of {v, waddr, rdy_stg}; each is reset to v=0, all other fields 0.
- Each clk edge:
  - flush=1: all v <= 0 (priority over everything).
  - else if adv=1: entry k+1 <= entry k.
  - Entry 0 <= {id_valid & id_wen & ~stall & (id_waddr!=0), id_waddr, id_rdy_stg}. A stall therefore inserts a bubble (v=0).
  - else (adv=0): all entries hold.
- The entry leaving stage NSTAGE-1 is discarded; WB is covered by the wb_* inputs.

Lookup (combinational, per port p)
- An entry matches when v=1 and waddr==rd_addr[p] and rd_addr[p]!=0.
- Search priority: stage 0 (youngest) first, then stage 1 ... stage NSTAGE-1, then WB (wb_wen & wb_waddr==rd_addr[p] & !=0), then GPR.
- The first matching stage k wins even if it is not ready; older matches are never used.
- Winner at stage k with k >= rdy_stg: op_data = stg_data[k], op_src = k+2.
- Winner at stage k with k < rdy_stg: port is not ready; op_data = gpr_data (don't-care), op_src = k+2.
- No stage match, WB match: op_data = wb_wdata, op_src = 1.
- No match at all: op_data = gpr_data[p], op_src = 0.
- rd_addr = 0 always resolves to GPR (src 0).

Stall
- stall = id_valid & ~flush & OR over p of (rd_en[p] & port p not ready).
- Purely combinational; zero latency.
- stall does not depend on adv. When adv=0 the tags are frozen, so stall is stable.

Statistics
- stall_cnt resets to 0.
- Increments on each clk where stall=1 and adv=1.
- Saturates at all-ones.
- Not cleared by flush.

Reset mid-operation
- Asynchronous clear of all v bits and stall_cnt.
- Outputs revert to GPR pass-through within the same cycle.

Decomposition:
- Shared package: tag entry struct {v, waddr[4:0], rdy_stg[SW-1:0]}, op_src encodings (SRC_GPR=0, SRC_WB=1, SRC_STG_BASE=2), REG_ZERO=5'd0.
- One natural sub-module, bypass_port_sel: a single port's priority search and mux, taking the entry vector, stg_data, wb_* and gpr_data and returning {op_data, op_src, not_ready}. Instantiate NUM_RD times via generate.

Test Plan:
- ALU back-to-back: issue add r5 (rdy_stg=0); next cycle ID reads r5 on port 0 -> op_src=2, op_data=stg_data[0]=32'h1234, stall=0.
- Load-use: lw r8 (rdy_stg=2) then ID reads r8 -> stall=1 for two adv cycles (tag at stages 0 and 1). Third cycle: op_src=4, op_data=stg_data[2], stall=0. stall_cnt=2.
- Youngest wins: r3 in stage 2 (ready) and stage 0 (rdy_stg=1, not ready) -> stall=1; stage 2's data is not forwarded.
- WB and r0: wb_wen=1, wb_waddr=7, wb_wdata=32'hCAFE, no tags for r7 -> op_src=1, op_data=32'hCAFE. A tag with waddr 0 is never created; reading r0 -> op_src=0.
- adv=0 hold: load tag in stage 0, adv=0 for 3 cycles -> tags frozen, stall stays 1, stall_cnt unchanged. adv=1 -> tag advances.
- Flush and reset: flush=1 while load is not ready -> next cycle all v=0, stall=0, op_src=0. Assert rst_n=0 mid-stall -> stall drops immediately, stall_cnt=0.
